// File: rtl/dmem_arb.sv
// Two-requester arbiter/sequencer for the single-port data memory (A = CPU LSU, B = debug/DMA).
// Optional DMEM_ARB_ROUND_ROBIN_EN replaces fixed priority + MAX_HOLD starvation limit with round robin.

`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module dmem_arb #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        a_req,
  input  logic                        a_we,
  input  logic [`DATA_ADDR_WIDTH-1:0] a_addr,
  input  logic [`WORD_SIZE-1:0]       a_wdata,
  output logic                        a_gnt,
  output logic                        a_rvalid,
  output logic [`WORD_SIZE-1:0]       a_rdata,
  input  logic                        b_req,
  input  logic                        b_we,
  input  logic [`DATA_ADDR_WIDTH-1:0] b_addr,
  input  logic [`WORD_SIZE-1:0]       b_wdata,
  output logic                        b_gnt,
  output logic                        b_rvalid,
  output logic [`WORD_SIZE-1:0]       b_rdata,
  output logic [`DATA_ADDR_WIDTH-1:0] m_addr,
  output logic                        m_read_en,
  output logic                        m_write_en,
  output logic [`WORD_SIZE-1:0]       m_write_data,
  input  logic [`WORD_SIZE-1:0]       m_read_data
);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;

  state_t state, next_state;
  port_t  winner;
  port_t  cur;
  logic   rd_pend;
  logic   issue;

  logic                        sel_we;
  logic [`DATA_ADDR_WIDTH-1:0] sel_addr;
  logic [`WORD_SIZE-1:0]       sel_wdata;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  port_t last_gnt;
`else
  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);
  logic [3:0] hold_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (a_req || b_req) next_state = ACCESS;
      ACCESS:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign issue = (state == IDLE) && (a_req || b_req);

  always_comb begin
    winner = PORT_A;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    if (a_req && b_req) winner = (last_gnt == PORT_A) ? PORT_B : PORT_A;
    else if (b_req)     winner = PORT_B;
`else
    if (b_req && (!a_req || hold_cnt >= HOLD_LIMIT)) winner = PORT_B;
`endif
  end

  assign sel_we    = (winner == PORT_B) ? b_we    : a_we;
  assign sel_addr  = (winner == PORT_B) ? b_addr  : a_addr;
  assign sel_wdata = (winner == PORT_B) ? b_wdata : a_wdata;

  // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_gnt        <= 1'b0;
      b_gnt        <= 1'b0;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      m_addr       <= '0;
      m_read_en    <= 1'b0;
      m_write_en   <= 1'b0;
      m_write_data <= '0;
      cur          <= PORT_A;
      rd_pend      <= 1'b0;
    end else begin
      a_gnt      <= 1'b0;
      b_gnt      <= 1'b0;
      m_read_en  <= 1'b0;
      m_write_en <= 1'b0;
      a_rvalid   <= rd_pend && (cur == PORT_A);
      b_rvalid   <= rd_pend && (cur == PORT_B);
      rd_pend    <= issue && !sel_we;
      // Memory clocks on the inverted clock, so its read word is ready by the edge ending ACCESS.
      if (rd_pend) begin
        if (cur == PORT_A) a_rdata <= m_read_data;
        else               b_rdata <= m_read_data;
      end
      if (issue) begin
        cur          <= winner;
        m_addr       <= sel_addr;
        m_write_data <= sel_wdata;
        m_write_en   <= sel_we;
        m_read_en    <= !sel_we;
        a_gnt        <= (winner == PORT_A);
        b_gnt        <= (winner == PORT_B);
      end
    end
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_gnt <= PORT_B;
    else if (issue) last_gnt <= winner;
  end
`else
  // Counts A grants made while B waits; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (issue) begin
      if (winner == PORT_B || !b_req) hold_cnt <= '0;
      else if (hold_cnt < HOLD_LIMIT) hold_cnt <= hold_cnt + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arb.sv
// Directed self-checking bench for dmem_arb; models the negedge-clocked data memory.
// Round-robin scenario is selected when DMEM_ARB_ROUND_ROBIN_EN is defined.

`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_dmem_arb;

  localparam int AW = `DATA_ADDR_WIDTH;
  localparam int DW = `WORD_SIZE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] m_addr;
  logic          m_read_en, m_write_en;
  logic [DW-1:0] m_write_data;
  logic [DW-1:0] m_read_data = '0;

  int vectors = 0;
  int miscompares = 0;
  int both_strobes = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  dmem_arb #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .m_addr(m_addr), .m_read_en(m_read_en), .m_write_en(m_write_en),
    .m_write_data(m_write_data), .m_read_data(m_read_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_write_en) mem[m_addr] <= m_write_data;
    if (m_read_en)  m_read_data <= mem[m_addr];
    if (m_read_en && m_write_en) both_strobes++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, m_addr,
         m_read_en, m_write_en, m_write_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: a_gnt=%b a_rv=%b a_rd=%h b_gnt=%b b_rv=%b b_rd=%h m_addr=%h re=%b we=%b wd=%h, required all 0",
               a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, m_addr, m_read_en, m_write_en, m_write_data);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_a_read();
    a_req = 1'b1; a_we = 1'b0; a_addr = AW'(5);
    step();
    vectors++;
    if ({a_gnt, b_gnt, m_read_en, m_write_en, m_addr} !== {4'b1010, AW'(5)}) begin
      miscompares++;
      $display("FAIL a_read_access: gnt a/b=%b%b re=%b we=%b addr=%0d, required 1 0 1 0 5",
               a_gnt, b_gnt, m_read_en, m_write_en, m_addr);
    end
    a_req = 1'b0;
    step();
    vectors++;
    if ({a_rvalid, a_rdata, a_gnt, m_read_en} !== {1'b1, DW'(16'h1234), 2'b00}) begin
      miscompares++;
      $display("FAIL a_read_data: rvalid=%b rdata=%h gnt=%b re=%b, required 1 1234 0 0",
               a_rvalid, a_rdata, a_gnt, m_read_en);
    end
    vectors++;
    if ({b_gnt, b_rvalid, b_rdata} !== '0) begin
      miscompares++;
      $display("FAIL a_read_b_quiet: b_gnt=%b b_rvalid=%b b_rdata=%h, required 0 0 0", b_gnt, b_rvalid, b_rdata);
    end
  endtask

  task automatic test_b_write_a_read();
    b_req = 1'b1; b_we = 1'b1; b_addr = AW'(3); b_wdata = DW'(16'hBEEF);
    step();
    vectors++;
    if ({b_gnt, a_gnt, m_write_en, m_read_en, m_addr, m_write_data} !== {4'b1010, AW'(3), DW'(16'hBEEF)}) begin
      miscompares++;
      $display("FAIL b_write_access: gnt b/a=%b%b we=%b re=%b addr=%0d wd=%h, required 1 0 1 0 3 beef",
               b_gnt, a_gnt, m_write_en, m_read_en, m_addr, m_write_data);
    end
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = AW'(3);
    step();
    step();
    vectors++;
    if ({a_gnt, m_read_en, m_addr} !== {2'b11, AW'(3)}) begin
      miscompares++;
      $display("FAIL a_read3_access: gnt=%b re=%b addr=%0d, required 1 1 3", a_gnt, m_read_en, m_addr);
    end
    a_req = 1'b0;
    step();
    vectors++;
    if ({a_rvalid, a_rdata, b_rvalid, b_rdata} !== {1'b1, DW'(16'hBEEF), 1'b0, DW'(0)}) begin
      miscompares++;
      $display("FAIL a_read3_data: a_rv=%b a_rd=%h b_rv=%b b_rd=%h, required 1 beef 0 0",
               a_rvalid, a_rdata, b_rvalid, b_rdata);
    end
  endtask

  task automatic test_idle_hold();
    a_req = 1'b1; a_we = 1'b1; a_addr = AW'(7); a_wdata = DW'(16'h0077);
    step();
    vectors++;
    if ({a_gnt, m_write_en, m_addr} !== {2'b11, AW'(7)}) begin
      miscompares++;
      $display("FAIL idle_write_access: gnt=%b we=%b addr=%0d, required 1 1 7", a_gnt, m_write_en, m_addr);
    end
    a_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if ({a_gnt, b_gnt, m_read_en, m_write_en, m_addr} !== {4'b0000, AW'(7)}) begin
        miscompares++;
        $display("FAIL idle_hold[%0d]: gnt a/b=%b%b re=%b we=%b addr=%0d, required 0 0 0 0 7",
                 i, a_gnt, b_gnt, m_read_en, m_write_en, m_addr);
      end
    end
  endtask

  task automatic run_grants(input string name, input string exp);
    string got;
    got = "";
    a_req = 1'b1; a_we = 1'b1; a_addr = AW'(20); a_wdata = DW'(1);
    b_req = 1'b1; b_we = 1'b1; b_addr = AW'(21); b_wdata = DW'(2);
    for (int i = 0; i < 2 * exp.len(); i++) begin
      step();
      if (a_gnt && b_gnt) got = {got, "X"};
      else if (a_gnt)     got = {got, "A"};
      else if (b_gnt)     got = {got, "B"};
    end
    a_req = 1'b0; b_req = 1'b0;
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: grant order %s, required %s", name, got, exp);
    end
    step();
  endtask

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    bit seen;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run_grants("rr_order", "ABABABABAB");
    b_req = 1'b1; b_we = 1'b1; b_addr = AW'(22);
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      step();
      if (b_gnt) seen = 1'b1;
    end
    b_req = 1'b0;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rr_lone_b: b_gnt not seen within 2 cycles, required 1");
    end
    step();
  endtask
`else
  task automatic test_starvation();
    run_grants("starvation_order", "AAAABAAAAB");
  endtask
`endif

  task automatic test_reset_mid_access();
    a_req = 1'b1; a_we = 1'b0; a_addr = AW'(5);
    step();
    vectors++;
    if ({a_gnt, m_read_en} !== 2'b11) begin
      miscompares++;
      $display("FAIL rst_pre_access: gnt=%b re=%b, required 1 1", a_gnt, m_read_en);
    end
    #2 rst_n = 1'b0;
    #1;
    a_req = 1'b0;
    vectors++;
    if ({a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, m_addr,
         m_read_en, m_write_en, m_write_data} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_access: a_gnt=%b re=%b we=%b addr=%h a_rd=%h, required all 0",
               a_gnt, m_read_en, m_write_en, m_addr, a_rdata);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({a_rvalid, a_gnt, m_read_en} !== 3'b000) begin
        miscompares++;
        $display("FAIL rst_no_rvalid[%0d]: rvalid=%b gnt=%b re=%b, required 0 0 0", i, a_rvalid, a_gnt, m_read_en);
      end
    end
    a_req = 1'b1; a_we = 1'b0; a_addr = AW'(5);
    step();
    vectors++;
    if ({a_gnt, m_read_en, m_addr} !== {2'b11, AW'(5)}) begin
      miscompares++;
      $display("FAIL rst_regrant: gnt=%b re=%b addr=%0d, required 1 1 5", a_gnt, m_read_en, m_addr);
    end
    a_req = 1'b0;
    step();
    vectors++;
    if ({a_rvalid, a_rdata} !== {1'b1, DW'(16'h1234)}) begin
      miscompares++;
      $display("FAIL rst_regrant_data: rvalid=%b rdata=%h, required 1 1234", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_strobe_exclusive();
    vectors++;
    if (both_strobes !== 0) begin
      miscompares++;
      $display("FAIL strobe_exclusive: %0d cycles with both strobes, required 0", both_strobes);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[5] = DW'(16'h1234);
    test_reset();
    test_a_read();
    test_b_write_a_read();
    test_idle_hold();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_starvation();
`endif
    test_reset_mid_access();
    test_strobe_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
